// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared state encoding and defaults for the unified memory arbiter
package unified_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUSY_IF  = 3'd1,
    BUSY_MEM = 3'd2,
    DONE_IF  = 3'd3,
    DONE_MEM = 3'd4
  } arb_state_t;

  localparam int unsigned DEFAULT_WAIT_STATES = 3;
  localparam int unsigned WAIT_CNT_W          = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - wait-state counter with clear, enable and terminal-count flag
module mem_wait_counter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned TERMINAL = DEFAULT_WAIT_STATES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == WAIT_CNT_W'(TERMINAL));

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port RAM between fetch and memory stage, memory stage first
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              freeze_if,
  output logic              freeze_pipe,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  arb_state_t        state;
  arb_state_t        next_state;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic              lat_we;
  logic              busy;
  logic              tc;
  logic              mem_req;

  assign mem_req = mem_rd_en | mem_wr_en;
  assign busy    = (state == BUSY_IF) || (state == BUSY_MEM);

  mem_wait_counter #(
    .TERMINAL (WAIT_STATES)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .clr (~busy),
    .en  (busy),
    .tc  (tc)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mem_req) begin
          next_state = BUSY_MEM;
        end else if (if_req) begin
          next_state = BUSY_IF;
        end
      end
      BUSY_IF:  if (tc) next_state = DONE_IF;
      BUSY_MEM: if (tc) next_state = DONE_MEM;
      DONE_IF:  next_state = IDLE;
      DONE_MEM: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Request fields are captured once on entry so the RAM sees a stable access
  // even if the requester drops or changes its inputs mid-access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == BUSY_MEM) begin
        lat_addr  <= mem_addr[ADDR_W+1:2];
        lat_wdata <= mem_wdata;
        lat_we    <= mem_wr_en & ~mem_rd_en;
      end else if (state == IDLE && next_state == BUSY_IF) begin
        lat_addr  <= if_addr[ADDR_W+1:2];
        lat_wdata <= '0;
        lat_we    <= 1'b0;
      end
      if (state == BUSY_IF && tc) begin
        if_rdata <= ram_rdata;
      end
      if (state == BUSY_MEM && tc && !lat_we) begin
        mem_rdata <= ram_rdata;
      end
    end
  end

  assign if_ready    = (state == DONE_IF);
  assign mem_ready   = (state == DONE_MEM);
  assign ram_en      = busy;
  assign ram_we      = (state == BUSY_MEM) && lat_we;
  assign ram_addr    = lat_addr;
  assign ram_wdata   = lat_wdata;
  assign freeze_pipe = mem_req & ~mem_ready;
  assign freeze_if   = freeze_pipe | (if_req & ~if_ready);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_rd_en, mem_wr_en;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
  logic        if_ready, mem_ready, freeze_if, freeze_pipe, ram_en, ram_we;
  logic [15:0] ram_addr;

  logic        b_rst, b_if_req, b_mem_rd_en, b_mem_wr_en;
  logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata;
  logic [31:0] b_if_rdata, b_mem_rdata, b_ram_wdata, b_ram_rdata;
  logic        b_if_ready, b_mem_ready, b_freeze_if, b_freeze_pipe, b_ram_en, b_ram_we;
  logic [15:0] b_ram_addr;

  logic [31:0] ram_a [0:63];
  logic [31:0] shadow [0:63];
  logic        ram_load;
  logic [5:0]  load_idx;
  logic [31:0] load_val;
  logic [31:0] model_if_rdata, model_mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.WAIT_STATES(WS), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze_if(freeze_if), .freeze_pipe(freeze_pipe),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  unified_mem_arbiter #(.WAIT_STATES(0), .ADDR_W(16)) dut_b (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .mem_rd_en(b_mem_rd_en), .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .freeze_if(b_freeze_if), .freeze_pipe(b_freeze_pipe),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  // Asynchronous-read RAM with a preload port; the second DUT sees a pattern ROM.
  assign ram_rdata   = ram_a[ram_addr[5:0]];
  assign b_ram_rdata = 32'hCAFE_0000 | {16'h0, b_ram_addr};

  always @(posedge clk) begin
    if (ram_load) ram_a[load_idx] <= load_val;
    else if (ram_en && ram_we) ram_a[ram_addr[5:0]] <= ram_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input bit is_fetch, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    int          idx;
    int          en_cnt;
    int          we_cnt;
    int          rdy_cyc;
    bit          is_write;
    logic [31:0] exp_data;
    idx      = int'(addr[7:2]);
    is_write = !is_fetch && wr && !rd;
    exp_data = shadow[idx];
    if (is_fetch) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      mem_rd_en = rd;
      mem_wr_en = wr;
      mem_addr  = addr;
      mem_wdata = wdata;
    end
    #1;
    check({tag, "_freeze_pipe_req"}, 32'(freeze_pipe), 32'(!is_fetch));
    check({tag, "_freeze_if_req"}, 32'(freeze_if), 32'd1);
    en_cnt  = 0;
    we_cnt  = 0;
    rdy_cyc = 0;
    for (int cyc = 1; cyc <= 40 && rdy_cyc == 0; cyc++) begin
      tick();
      if (ram_en) begin
        en_cnt++;
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'(addr[17:2]));
        if (is_write) check({tag, "_ram_wdata"}, ram_wdata, wdata);
      end
      if (ram_we) we_cnt++;
      check({tag, "_other_ready"}, 32'(is_fetch ? mem_ready : if_ready), 32'd0);
      if (is_fetch ? if_ready : mem_ready) rdy_cyc = cyc;
    end
    check({tag, "_latency"}, 32'(rdy_cyc), 32'(WS + 2));
    check({tag, "_ram_en_cycles"}, 32'(en_cnt), 32'(WS + 1));
    check({tag, "_ram_we_cycles"}, 32'(we_cnt), is_write ? 32'(WS + 1) : 32'd0);
    check({tag, "_freeze_pipe_done"}, 32'(freeze_pipe), 32'd0);
    check({tag, "_freeze_if_done"}, 32'(freeze_if), 32'd0);
    if (is_write) shadow[idx] = wdata;
    else if (is_fetch) model_if_rdata = exp_data;
    else model_mem_rdata = exp_data;
    check({tag, "_if_rdata"}, if_rdata, model_if_rdata);
    check({tag, "_mem_rdata"}, mem_rdata, model_mem_rdata);
    if_req    = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    tick();
    check({tag, "_ready_one_cycle"}, 32'({if_ready, mem_ready}), 32'd0);
  endtask

  initial begin
    int          m_rdy;
    int          i_rdy;
    int          op;
    logic [31:0] r;
    logic [31:0] a;

    rst = 1'b0; b_rst = 1'b0;
    if_req = 1'b0; if_addr = '0; mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_addr = '0; mem_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_mem_rd_en = 1'b0; b_mem_wr_en = 1'b0;
    b_mem_addr = '0; b_mem_wdata = '0;
    ram_load = 1'b0; load_idx = '0; load_val = '0;
    model_if_rdata = '0; model_mem_rdata = '0;

    tick();
    for (int i = 0; i < 64; i++) begin
      shadow[i] = (i == 8) ? 32'hE3A0_1005 : $urandom;
      ram_load  = 1'b1;
      load_idx  = 6'(i);
      load_val  = shadow[i];
      tick();
    end
    ram_load = 1'b0;

    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_freeze", 32'({freeze_if, freeze_pipe}), 32'd0);

    rst = 1'b1;
    tick();

    do_access(1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, "fetch_0x20");
    do_access(1'b0, 1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, "store_0x404");
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0404, 32'h0, "load_0x404");
    check("load_0x404_value", mem_rdata, 32'hDEAD_BEEF);
    do_access(1'b0, 1'b1, 1'b1, 32'h0000_0414, 32'h5555_AAAA, "rd_wr_both");

    // Fetch and load arrive together: load is served first, fetch after one idle cycle.
    if_req = 1'b1; if_addr = 32'h20; mem_rd_en = 1'b1; mem_addr = 32'h400;
    m_rdy = 0; i_rdy = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) check("simul_first_addr", 32'(ram_addr), 32'h100);
      if (c == 7) check("simul_second_addr", 32'(ram_addr), 32'h8);
      check("simul_freeze_if", 32'(freeze_if), 32'(c < 11));
      if (mem_ready && m_rdy == 0) begin m_rdy = c; mem_rd_en = 1'b0; end
      if (if_ready && i_rdy == 0) begin i_rdy = c; if_req = 1'b0; end
    end
    model_mem_rdata = shadow[0];
    model_if_rdata  = shadow[8];
    check("simul_mem_ready_cycle", 32'(m_rdy), 32'd5);
    check("simul_if_ready_cycle", 32'(i_rdy), 32'd11);
    check("simul_mem_rdata", mem_rdata, model_mem_rdata);
    check("simul_if_rdata", if_rdata, model_if_rdata);

    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 3));
      r  = $urandom;
      a  = (r & 32'hFFFC_0003) | (32'($urandom_range(0, 63)) << 2);
      case (op)
        0:       do_access(1'b1, 1'b0, 1'b0, a, 32'h0, "rand_fetch");
        1:       do_access(1'b0, 1'b1, 1'b0, a, $urandom, "rand_load");
        2:       do_access(1'b0, 1'b0, 1'b1, a, $urandom, "rand_store");
        default: do_access(1'b0, 1'b1, 1'b1, a, $urandom, "rand_both");
      endcase
    end

    // Reset lands in the second busy cycle of a store.
    mem_wr_en = 1'b1; mem_addr = 32'h408; mem_wdata = 32'h1234_5678;
    tick();
    tick();
    rst = 1'b0;
    tick();
    shadow[2] = 32'h1234_5678;
    model_if_rdata = '0;
    model_mem_rdata = '0;
    check("abort_ram_en", 32'(ram_en), 32'd0);
    check("abort_ram_we", 32'(ram_we), 32'd0);
    check("abort_mem_ready", 32'(mem_ready), 32'd0);
    check("abort_mem_rdata", mem_rdata, 32'd0);
    mem_wr_en = 1'b0;
    tick();
    check("abort_mem_ready_later", 32'(mem_ready), 32'd0);
    rst = 1'b1;
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0408, 32'h0, "first_after_rst");

    b_rst = 1'b1;
    tick();
    b_mem_rd_en = 1'b1; b_mem_addr = 32'h10;
    tick();
    check("ws0_ram_en_c1", 32'(b_ram_en), 32'd1);
    check("ws0_ram_addr_c1", 32'(b_ram_addr), 32'd4);
    check("ws0_ready_c1", 32'(b_mem_ready), 32'd0);
    tick();
    check("ws0_ram_en_c2", 32'(b_ram_en), 32'd0);
    check("ws0_ready_c2", 32'(b_mem_ready), 32'd1);
    check("ws0_rdata", b_mem_rdata, 32'hCAFE_0004);
    b_mem_rd_en = 1'b0;
    tick();
    check("ws0_ready_c3", 32'(b_mem_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 3, extra RAM cycles per access; legal range 0..15.
REQ-002 Parameter ADDR_W, default 16, RAM word-address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 if_req  input  1  fetch stage requests an instruction word; held until if_ready.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_rdata  output  32  fetched word (registered).
REQ-008 if_ready  output  1  one-cycle pulse: if_rdata valid.
REQ-009 mem_rd_en, mem_wr_en  input  1 each  memory-stage load/store request; held until mem_ready.
REQ-010 mem_addr, mem_wdata  input  32 each  memory-stage byte address and store data.
REQ-011 mem_rdata  output  32  load result (registered).
REQ-012 mem_ready  output  1  one-cycle pulse: load/store complete.
REQ-013 freeze_if  output  1  stall fetch PC and IF/ID register.
REQ-014 freeze_pipe  output  1  stall all pipeline registers behind the memory stage.
REQ-015 ram_en, ram_we  output  1 each  shared single-port RAM enable and write strobe.
REQ-016 ram_addr  output  ADDR_W  RAM word address = selected byte address bits [ADDR_W+1:2].
REQ-017 ram_wdata  output  32 / ram_rdata  input  32  RAM data buses.

Function
REQ-018 FSM states are IDLE, BUSY_IF, BUSY_MEM, DONE_IF and DONE_MEM.
REQ-019 IDLE: if mem_rd_en|mem_wr_en, go to BUSY_MEM; else if if_req, go to BUSY_IF; else stay in IDLE.
REQ-020 The memory stage has fixed priority over fetch, because it holds the older instruction.
REQ-021 On entry to BUSY_*, address, write data and op SHALL be latched; ram_* outputs SHALL drive the latched values, stable for the whole access.
REQ-022 In BUSY_*, the 4-bit wait counter counts 0..WAIT_STATES; after the cycle in which count = WAIT_STATES, the FSM moves to DONE_*.
REQ-023 On the BUSY->DONE edge: a read loads ram_rdata into if_rdata or mem_rdata; a write leaves mem_rdata unchanged.
REQ-024 DONE_* lasts one cycle and asserts the matching ready; the next state is always IDLE; requests are ignored while in DONE_*.
REQ-025 Latency: for a request first sampled at edge 1, ready is high in cycle WAIT_STATES+2.
REQ-026 ram_en is high in BUSY_* only; ram_we is high in BUSY_MEM only, and only for a write.
REQ-027 If mem_rd_en and mem_wr_en are both high, the access is a read and the write is dropped.
REQ-028 If a request is dropped mid-access, the access still completes and the ready pulse is still emitted.
REQ-029 freeze_pipe = (mem_rd_en|mem_wr_en) & ~mem_ready, combinational.
REQ-030 freeze_if = freeze_pipe | (if_req & ~if_ready), combinational.
REQ-031 The arbiter allows back-to-back accesses with a minimum 1-cycle IDLE gap between accesses.

Reset
REQ-032 While rst=0 at a clock edge: FSM goes to IDLE, counter 0, latched fields 0, if_rdata/mem_rdata 0, if_ready/mem_ready/ram_en/ram_we 0.
REQ-033 Reset during BUSY_* aborts the access: no ready pulse, and ram_we is low from the next cycle.
REQ-034 The first request SHALL be accepted at the first edge after rst returns to 1.

Structure
REQ-035 State encodings and the default WAIT_STATES value SHALL reside in the shared arbiter header/package.
REQ-036 The wait counter SHALL be the sub-module mem_wait_counter, with clear and enable inputs and a terminal-count output.
REQ-037 Everything else (FSM, latches, output registers) resides in unified_mem_arbiter.

Verification
REQ-038 Fetch read: WAIT_STATES=3, RAM word 8=0xE3A01005, if_req with if_addr=0x20 -> ram_addr=8 for 4 cycles; if_ready in cycle 5 with if_rdata=0xE3A01005.
REQ-039 Simultaneous if_req (0x20) and mem_rd_en (0x400) -> ram_addr=0x100 served first; mem_ready in cycle 5 and if_ready in cycle 11; freeze_if high until cycle 11.
REQ-040 Store then load: mem_wr_en to 0x404 with 0xDEADBEEF -> ram_we high 4 cycles; subsequent load from 0x404 -> mem_rdata=0xDEADBEEF.
REQ-041 rst=0 during the second BUSY_MEM cycle of a store -> IDLE next cycle, ram_en=ram_we=0, no mem_ready pulse, mem_rdata=0.
REQ-042 WAIT_STATES=0, single load -> ram_en for 1 cycle, mem_ready in cycle 2.
REQ-043 mem_rd_en=mem_wr_en=1 -> ram_we never asserted, read data returned with mem_ready.
